// File: rtl/seven_seg_pkg.sv
// Shared types, constants and segment lookup for the seven-segment scan controller.
package seven_seg_pkg;

  // Scan slot phase: all anodes dark, or one digit lit.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  // Everything captured in one load transfer and later committed as a unit.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic [3:0]  digit_en;
    logic        lz_blank;
  } disp_cfg_t;

  localparam disp_cfg_t CFG_RESET = '{
    value:    16'h0000,
    dp_en:    4'h0,
    digit_en: 4'hF,
    lz_blank: 1'b0
  };

  // Nibble to active-low segment pattern; non-BCD codes render as a dash.
  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // True when any of the four nibbles is outside 0..9.
  function automatic logic bcd_has_invalid(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_decode.sv
// Combinational single-digit decoder: BCD nibble to active-low segments.
module seg_digit_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o,
  output logic       invalid_o
);

  // Table lookup plus a flag for codes that are not decimal digits.
  always_comb begin
    seg_n_o   = seg_lut(nibble_i);
    invalid_o = (nibble_i > 4'd9);
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with double-buffered
// display value, per-digit blanking gap and leading-zero suppression.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000,
  parameter int CNT_W           = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_bcd,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_start,
  output logic        bcd_error
);

  localparam bit               HAS_BLANK  = (BLANK_TICKS > 0);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = HAS_BLANK ? CNT_W'(BLANK_TICKS - 1) : '0;
  // Each slot starts dark unless the gap is configured away.
  localparam scan_state_e      ENTRY_STATE = scan_state_e'(HAS_BLANK ? 1'b0 : 1'b1);

  // Scan state
  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             wrap_s;

  // Load / commit state
  disp_cfg_t pend_q;
  logic      pend_valid_q;
  logic      ready_q;
  disp_cfg_t shadow_q, shadow_d;
  logic      err_q;

  // Registered pin drivers
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       fs_q, fs_d;

  // Digit selection and decode
  logic [3:0] nib_s;
  logic [6:0] dec_seg_s;
  logic       dec_invalid_s;
  logic [3:0] lz_mask_s;
  logic       lit_s;

  // Scan state and pin registers; outputs are loaded from the next-state
  // decode so they change in the same cycle as the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY_STATE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
    end
  end

  // Next scan state: dwell counter, phase and digit index advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    idx_d   = idx_q;
    wrap_s  = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          state_d = BLANK;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ENTRY_STATE;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          wrap_s  = (idx_q == 2'd3);
        end else begin
          state_d = SHOW;
        end
      end
      default: begin
        state_d = ENTRY_STATE;
        cnt_d   = '0;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Display value seen by the decoder: pending config lands at the frame wrap.
  always_comb begin
    if (wrap_s && pend_valid_q) begin
      shadow_d = pend_q;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Handshake and double buffer. ready is low exactly while pending is
  // occupied, so a transfer and a commit never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= CFG_RESET;
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      shadow_q     <= CFG_RESET;
      err_q        <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (wrap_s && pend_valid_q) begin
        err_q        <= bcd_has_invalid(pend_q.value);
        pend_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else if (load_valid && ready_q) begin
        pend_q       <= '{value: value_bcd, dp_en: dp_en,
                          digit_en: digit_en, lz_blank: lz_blank};
        pend_valid_q <= 1'b1;
        ready_q      <= 1'b0;
      end else begin
        pend_valid_q <= pend_valid_q;
      end
    end
  end

  // Leading-zero mask: a digit is suppressed while it and every digit to its
  // left are zero; the rightmost digit always shows.
  always_comb begin
    lz_mask_s    = 4'b0000;
    lz_mask_s[3] = shadow_d.lz_blank && (shadow_d.value[15:12] == 4'd0);
    lz_mask_s[2] = lz_mask_s[3] && (shadow_d.value[11:8] == 4'd0);
    lz_mask_s[1] = lz_mask_s[2] && (shadow_d.value[7:4] == 4'd0);
  end

  // Select the nibble of the digit about to be driven.
  always_comb begin
    nib_s = shadow_d.value[{idx_d, 2'b00} +: 4];
    lit_s = shadow_d.digit_en[idx_d] && !lz_mask_s[idx_d];
  end

  seg_digit_decode u_decode (
    .nibble_i  (nib_s),
    .seg_n_o   (dec_seg_s),
    .invalid_o (dec_invalid_s)
  );

  // Pin values for the upcoming state; only a lit SHOW slot drives anything.
  always_comb begin
    an_d = AN_OFF;
    seg_d = SEG_OFF;
    dp_d = 1'b1;
    fs_d = 1'b0;
    if (state_d == SHOW) begin
      fs_d = (idx_d == 2'd0) && (cnt_d == '0);
      if (lit_s) begin
        an_d = ~(4'b0001 << idx_d);
        if (dec_invalid_s) begin
          seg_d = SEG_DASH;
        end else begin
          seg_d = dec_seg_s;
        end
        dp_d = ~shadow_d.dp_en[idx_d];
      end else begin
        an_d = AN_OFF;
      end
    end else begin
      fs_d = 1'b0;
    end
  end

  assign an_n        = an_q;
  assign seg_n       = seg_q;
  assign dp_n        = dp_q;
  assign frame_start = fs_q;
  assign load_ready  = ready_q;
  assign bcd_error   = err_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the Fitbit replica board. It accepts a packed 4-digit BCD value through a valid/ready load handshake and double-buffers it so updates land only on frame boundaries. It cycles the active-low anodes with a programmable dwell and inter-digit blanking gap, and decodes each digit to active-low segments. It sits between the step/time counters and the board pins, replacing the per-digit decoder in top-level wiring.

Parameters:
TICKS_PER_DIGIT, 100000, clk cycles each digit is lit (1 ms at 100 MHz); must be >= 1
BLANK_TICKS, 1000, clk cycles all anodes are off before each digit (anti-ghosting); 0 skips the BLANK state
CNT_W, 17, width of the dwell counter; must hold max(TICKS_PER_DIGIT, BLANK_TICKS) - 1

Ports:
clk  in  1  system clock, all state rising-edge
rst_n  in  1  asynchronous active-low reset
value_bcd  in  16  digits {d3,d2,d1,d0}, 4 bits each; d0 is rightmost
dp_en  in  4  decimal-point enable per digit, captured with value_bcd
digit_en  in  4  per-digit enable, captured with value_bcd; 0 keeps that anode off
lz_blank  in  1  leading-zero blanking enable, captured with value_bcd
load_valid  in  1  producer presents new value
load_ready  out  1  controller can accept a value
seg_n  out  7  {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point, active-low
an_n  out  4  anode select, active-low, bit i = digit i
frame_start  out  1  one-cycle pulse when digit 0 enters SHOW
bcd_error  out  1  committed value holds a nibble > 9

Behaviour:
- Reset (async, immediate): an_n=4'b1111, seg_n=7'h7F, dp_n=1, load_ready=1, frame_start=0, bcd_error=0. Shadow and pending registers are cleared to 0, with digit_en=4'hF and lz_blank=0. Digit index=0, state=BLANK (SHOW if BLANK_TICKS=0). Reset mid-frame restarts scan at digit 0.
- FSM, per digit slot:
  - BLANK: lasts BLANK_TICKS cycles; an_n=1111, seg_n=7F, dp_n=1.
  - SHOW: lasts TICKS_PER_DIGIT cycles; an_n drives bit idx low, unless the digit is disabled or blanked, in which case all anodes stay high and segments are off.
  - Transitions: the last SHOW cycle goes to BLANK (or directly to SHOW when BLANK_TICKS=0) with idx = idx+1 mod 4. Slot length = B+T; frame length = 4*(B+T).
- Outputs are registered: anode/segment values for a state appear in the same cycle as the state register.
- Handshake:
  - A transfer occurs when load_valid && load_ready on a rising edge; all inputs are captured into pending.
  - load_ready drops the next cycle and stays low until commit.
- Commit (frame boundary):
  - Happens in the cycle idx wraps 3->0. Pending is copied to shadow and load_ready returns high the following cycle.
  - A transfer in the wrap cycle itself is held in pending and commits at the next boundary. There is no bypass.
  - With no pending value at the boundary, shadow is unchanged.
- Decode, from shadow only: 0..9 use standard segments (0=7'b1000000, 1=7'b1111001, 8=7'b0000000). Nibbles A..F display a dash, 7'b0111111.
- bcd_error is updated at each commit: 1 if any shadow nibble > 9, else 0.
- Leading-zero blanking: when lz_blank=1, d3..d1 are blanked while zero and all higher digits are zero. d0 is never blanked.
- dp_n = ~dp_en[idx] during SHOW of an enabled, non-blanked digit; else 1.
- frame_start pulses in the first SHOW cycle of idx 0, even if digit 0 is disabled.

Decomposition:
- Package seven_seg_pkg holds:
  - state enum {BLANK, SHOW};
  - the SEG_DASH and SEG_OFF constants;
  - the 16-entry segment lookup as a constant function.
- One sub-module, seg_digit_decode: a combinational 4-bit nibble in, 7-bit active-low segment pattern and invalid flag out. It is instantiated once, muxed by idx.

Test Plan:
- Use TICKS_PER_DIGIT=4, BLANK_TICKS=2. Reset release -> an_n=1111 for 2 cycles, then 1110 for 4 cycles with seg_n=7'b1000000. frame_start pulses once per 24 cycles.
- Load 16'h1234 with dp_en=4'b0100, mid-frame -> load_ready low until wrap, then high. The next frame shows d0=4, d1=3, d2=2, d3=1, and dp_n=0 only while an_n=1011.
- Load 16'h0007 with lz_blank=1 -> only an_n=1110 ever asserts; an_n=0111/1011/1101 never appear. With lz_blank=0, all four digits light, showing 0,0,0,7.
- Load 16'h00A5 -> d1 shows 7'b0111111 and bcd_error=1 after commit. A later load of 16'h0005 clears bcd_error at its commit.
- Assert load_valid exactly in the wrap cycle -> value is not shown this frame and appears one frame later. load_ready stays low for a full frame.
- Assert rst_n low during SHOW of digit 2 -> an_n=1111 and seg_n=7F asynchronously. After release, scan restarts at BLANK of digit 0 with shadow=0.
